// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
// Contents:
//   imem_state_t : responder FSM encoding (IDLE/WAIT/RESP, 2'b11 unused)
//   imem_err_t   : response error code carried on rsp_err
//   NOP_WORD     : default word returned for errored fetches
//   classify_addr: error classification of a byte address against the array depth
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } imem_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10
  } imem_err_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Misalignment is checked first so a misaligned, out-of-range address reports 01.
  function automatic imem_err_t classify_addr(input logic [31:0] addr, input int unsigned depth);
    if (addr[1:0] != 2'b00) begin
      return ERR_MISALIGN;
    end
    if ({2'b00, addr[31:2]} >= depth) begin
      return ERR_RANGE;
    end
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage.
// Ports:
//   clk   : clock, all activity on posedge
//   we    : write enable, writes wdata at waddr on the edge
//   waddr : write word index
//   wdata : write data
//   rd_en : read enable; rdata updates on the edge and then holds until the next rd_en
//   raddr : read word index
//   rdata : registered read data, valid the cycle after rd_en
// Contents are never reset.
module imem_array #(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          rd_en,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (rd_en) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Memory-side responder for the core's instruction-fetch request/response interface.
// A request accepted in IDLE is answered LATENCY cycles later; the response is held
// until rsp_ready. Bad addresses return ERR_WORD with an error code.
// Optional feature: define IMEM_PERF_CNT_EN to add the perf_fetches counter port.
// Ports:
//   clk, rst_n    : clock and synchronous active-low reset
//   req_valid/ready/addr : fetch request (byte address)
//   rsp_valid/ready/data/err : fetch response (err 00 ok, 01 misaligned, 10 out-of-range)
//   ld_we/addr/data : preload write port, honoured only in IDLE
//   busy          : FSM not in IDLE
//   state_vector  : raw FSM state for diagnostics
//   perf_fetches  : completed-response count (IMEM_PERF_CNT_EN only)
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LATENCY  = 2,
  parameter logic [31:0] ERR_WORD = NOP_WORD,
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic [1:0]    rsp_err,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          busy,
  output logic [1:0]    state_vector
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetches
`endif
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("imem_fetch_responder: LATENCY must be 1..15");
  end

  imem_state_t state_q;
  logic [3:0]  lat_q;
  imem_err_t   err_q;
  // Set once a response has been captured; keeps rsp_data at zero out of reset
  // since the array read register itself is not reset.
  logic        data_ok_q;

  imem_err_t   req_err;
  logic        accept;
  logic        rd_en;
  logic        mem_we;
  logic        rsp_hs;
  logic [31:0] rd_data;

  assign req_ready = (state_q == IDLE) && !ld_we;
  assign accept    = req_valid && req_ready;
  assign req_err   = classify_addr(req_addr, DEPTH);
  // The array read register doubles as the response data holder: it only updates
  // on an accepted, error-free request, so later preloads cannot disturb it.
  assign rd_en     = accept && (req_err == ERR_NONE);
  assign mem_we    = ld_we && (state_q == IDLE);
  assign rsp_hs    = (state_q == RESP) && rsp_ready;

  imem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(ld_addr),
    .wdata(ld_data),
    .rd_en(rd_en),
    .raddr(req_addr[AW+1:2]),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      err_q     <= ERR_NONE;
      data_ok_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            err_q     <= req_err;
            data_ok_q <= 1'b1;
            if (LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              lat_q   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          lat_q <= lat_q - 4'd1;
          if (lat_q == 4'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid    = (state_q == RESP);
  assign rsp_err      = err_q;
  assign rsp_data     = !data_ok_q              ? 32'h0 :
                        (err_q != ERR_NONE)     ? ERR_WORD : rd_data;
  assign busy         = (state_q != IDLE);
  assign state_vector = state_q;

`ifdef IMEM_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (rsp_hs) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_fetches = perf_q;
`else
  logic unused_hs;
  assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench: three responders (LATENCY 2, 1, 15) sharing clock and reset.
module tb_imem_fetch_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid    [3];
  logic        req_ready    [3];
  logic [31:0] req_addr     [3];
  logic        rsp_valid    [3];
  logic        rsp_ready    [3];
  logic [31:0] rsp_data     [3];
  logic [1:0]  rsp_err      [3];
  logic        ld_we        [3];
  logic [9:0]  ld_addr      [3];
  logic [31:0] ld_data      [3];
  logic        busy         [3];
  logic [1:0]  state_vector [3];
`ifdef IMEM_PERF_CNT_EN
  logic [31:0] perf_fetches [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_fetch_responder #(
      .DEPTH  (1024),
      .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : 15)
    ) u (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_addr    (req_addr[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_ready   (rsp_ready[g]),
      .rsp_data    (rsp_data[g]),
      .rsp_err     (rsp_err[g]),
      .ld_we       (ld_we[g]),
      .ld_addr     (ld_addr[g]),
      .ld_data     (ld_data[g]),
      .busy        (busy[g]),
      .state_vector(state_vector[g])
`ifdef IMEM_PERF_CNT_EN
      ,
      .perf_fetches(perf_fetches[g])
`endif
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input int d, input int idx, input logic [31:0] data);
    ld_we[d]   = 1'b1;
    ld_addr[d] = 10'(idx);
    ld_data[d] = data;
    @(negedge clk);
    ld_we[d]   = 1'b0;
  endtask

  // Issue one fetch with rsp_ready high; returns at the first cycle back in IDLE.
  task automatic do_fetch(input int d, input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_err, input int lat);
    int n;
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    #1;
    check_eq("req_ready_idle", req_ready[d], 1);
    @(negedge clk);
    req_valid[d] = 1'b0;
    n = 1;
    while (!rsp_valid[d] && n <= 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("latency", n, lat);
    check_eq("rsp_data", rsp_data[d], exp_data);
    check_eq("rsp_err", rsp_err[d], exp_err);
    @(negedge clk);
    check_eq("idle_after_rsp", state_vector[d], 0);
  endtask

  initial begin
    int n;
    logic stale;
`ifdef IMEM_PERF_CNT_EN
    logic [31:0] perf_base;
`endif
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0;
      req_addr[d]  = '0;
      rsp_ready[d] = 1'b1;
      ld_we[d]     = 1'b0;
      ld_addr[d]   = '0;
      ld_data[d]   = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_state", state_vector[0], 0);
    check_eq("rst_rsp_valid", rsp_valid[0], 0);
    check_eq("rst_rsp_data", rsp_data[0], 0);
    check_eq("rst_rsp_err", rsp_err[0], 0);
    check_eq("rst_busy", busy[0], 0);
    check_eq("rst_req_ready", req_ready[0], 1);
`ifdef IMEM_PERF_CNT_EN
    check_eq("rst_perf", perf_fetches[0], 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    preload(0, 0, 32'h0050_0093);
    preload(0, 1, 32'h00A0_0113);
    preload(0, 3, 32'h1111_1111);
    preload(0, 5, 32'h5555_5555);
    for (int i = 0; i < 10; i++) begin
      preload(1, i, 32'hA000_0000 + i);
      preload(2, i, 32'hB000_0000 + i);
    end

    // Basic fetch
    do_fetch(0, 32'h0, 32'h0050_0093, 2'b00, 2);

    // Backpressure: hold rsp_ready low for 5 cycles in RESP
`ifdef IMEM_PERF_CNT_EN
    perf_base = perf_fetches[0];
`endif
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h4;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 1;
    while (!rsp_valid[0] && n <= 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_valid_hold", rsp_valid[0], 1);
      check_eq("bp_data_hold", rsp_data[0], 32'h00A0_0113);
      check_eq("bp_err_hold", rsp_err[0], 0);
      check_eq("bp_req_ready", req_ready[0], 0);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check_eq("bp_done_state", state_vector[0], 0);
    @(negedge clk);
    check_eq("bp_single_rsp", rsp_valid[0], 0);
`ifdef IMEM_PERF_CNT_EN
    check_eq("bp_perf_one", perf_fetches[0], perf_base + 1);
`endif

    // Errors
    do_fetch(0, 32'h6, 32'h0000_0013, 2'b01, 2);
    do_fetch(0, 32'h1000, 32'h0000_0013, 2'b10, 2);
    do_fetch(0, 32'h4002, 32'h0000_0013, 2'b01, 2);

    // Preload collides with a request in IDLE: write wins, request goes next cycle
    ld_we[0]     = 1'b1;
    ld_addr[0]   = 10'd3;
    ld_data[0]   = 32'hCAFE_0003;
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'hC;
    #1;
    check_eq("coll_req_ready", req_ready[0], 0);
    @(negedge clk);
    ld_we[0] = 1'b0;
    check_eq("coll_no_accept", state_vector[0], 0);
    do_fetch(0, 32'hC, 32'hCAFE_0003, 2'b00, 2);

    // Preload during WAIT is dropped
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h14;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check_eq("wait_state", state_vector[0], 1);
    ld_we[0]   = 1'b1;
    ld_addr[0] = 10'd5;
    ld_data[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    ld_we[0] = 1'b0;
    check_eq("wait_ld_rsp", rsp_data[0], 32'h5555_5555);
    @(negedge clk);
    do_fetch(0, 32'h14, 32'h5555_5555, 2'b00, 2);

    // Reset during WAIT drops the response; contents survive
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check_eq("mid_wait", state_vector[0], 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_rst_state", state_vector[0], 0);
    check_eq("mid_rst_valid", rsp_valid[0], 0);
    check_eq("mid_rst_data", rsp_data[0], 0);
    stale = 1'b0;
    repeat (4) begin
      @(negedge clk);
      stale = stale | rsp_valid[0];
    end
    check_eq("no_stale_rsp", stale, 0);
    do_fetch(0, 32'h0, 32'h0050_0093, 2'b00, 2);

    // Latency sweep, back-to-back with rsp_ready high
    for (int i = 0; i < 10; i++) begin
      do_fetch(1, 32'(i * 4), 32'hA000_0000 + i, 2'b00, 1);
    end
    for (int i = 0; i < 10; i++) begin
      do_fetch(2, 32'(i * 4), 32'hB000_0000 + i, 2'b00, 15);
    end
`ifdef IMEM_PERF_CNT_EN
    check_eq("perf_lat1", perf_fetches[1], 10);
    check_eq("perf_lat15", perf_fetches[2], 10);
    force g_dut[1].u.perf_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release g_dut[1].u.perf_q;
    do_fetch(1, 32'h6, 32'h0000_0013, 2'b01, 1);
    check_eq("perf_wrap", perf_fetches[1], 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
